aes_round_sched: RTL and testbench

AES_ROUND_SCHED -- requirements
Module: aes_round_sched

---
 rtl/aes_pkg.sv | 27 ++
 rtl/aes_round_sched_if.sv | 39 +++
 rtl/aes_round_sched.sv | 138 +++++++++++++
 tb/tb_aes_round_sched.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AES decryption round scheduler: one-hot state
// encoding, statemt RAM owner codes and the legal round counts.
package aes_pkg;

  typedef enum logic [7:0] {
    S_IDLE = 8'b0000_0001,
    S_ARK0 = 8'b0000_0010,
    S_BSS  = 8'b0000_0100,
    S_ARK  = 8'b0000_1000,
    S_MIX  = 8'b0001_0000,
    S_BSSL = 8'b0010_0000,
    S_ARKL = 8'b0100_0000,
    S_DONE = 8'b1000_0000
  } state_e;

  typedef enum logic [1:0] {
    MEM_NONE = 2'd0,
    MEM_ARK  = 2'd1,
    MEM_BSS  = 2'd2,
    MEM_MIX  = 2'd3
  } mem_sel_e;

  localparam int unsigned NR_10 = 10;
  localparam int unsigned NR_12 = 12;
  localparam int unsigned NR_14 = 14;

endpackage

// File: rtl/aes_round_sched_if.sv
// Control/handshake bundle between the round scheduler, its host and the
// AddRoundKey / InvSubBytes+InvShiftRows / InvMixColumns engines.
interface aes_round_sched_if
  import aes_pkg::*;
#(
  parameter int NR_W = 5
) ();

  logic            ap_start;
  logic [NR_W-1:0] nr;
  logic            ap_done;
  logic            ap_idle;
  logic            ap_ready;
  logic            err;
  logic            ark_start;
  logic            ark_done;
  logic [NR_W-1:0] ark_n;
  logic            bss_start;
  logic            bss_done;
  logic            mix_start;
  logic            mix_done;
  mem_sel_e        mem_sel;
  logic [NR_W-1:0] round;

  // Scheduler side
  modport slave (
    input  ap_start, nr, ark_done, bss_done, mix_done,
    output ap_done, ap_idle, ap_ready, err,
    output ark_start, ark_n, bss_start, mix_start, mem_sel, round
  );

  // Host/engine side
  modport master (
    output ap_start, nr, ark_done, bss_done, mix_done,
    input  ap_done, ap_idle, ap_ready, err,
    input  ark_start, ark_n, bss_start, mix_start, mem_sel, round
  );

endinterface

// File: rtl/aes_round_sched.sv
// AES decryption round scheduler: sequences AddRoundKey, InvSubBytes/
// InvShiftRows and InvMixColumns engines over nr rounds and arbitrates the
// shared statemt RAM through mem_sel.
//
// state | meaning
// IDLE  | waiting for ap_start; captures nr and round := nr-1
// ARK0  | initial AddRoundKey with key index nr
// BSS   | InvShiftRows/InvSubBytes of a middle round
// ARK   | AddRoundKey with key index round
// MIX   | InvMixColumns; steps round down or leaves for the last round
// BSSL  | InvShiftRows/InvSubBytes of the last round
// ARKL  | final AddRoundKey with key index 0
// DONE  | one-cycle ap_done/ap_ready pulse (err if nr was illegal)
module aes_round_sched
  import aes_pkg::*;
#(
  parameter int NR_W = 5
) (
  input logic               ap_clk,
  input logic               ap_rst,
  aes_round_sched_if.slave  bus
);

  state_e          state_q, state_d;
  logic [NR_W-1:0] round_q, round_d;
  logic [NR_W-1:0] nr_q, nr_d;
  logic            err_q, err_d;
  logic            nr_ok;

  // Only the three AES key sizes are accepted.
  always_comb begin
    nr_ok = (bus.nr == NR_W'(NR_10)) || (bus.nr == NR_W'(NR_12)) ||
            (bus.nr == NR_W'(NR_14));
  end

  // State, round counter, latched nr and error flag registers.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= S_IDLE;
      round_q <= '0;
      nr_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      nr_q    <= nr_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; each phase advances only on its own engine's done.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    nr_d    = nr_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.ap_start) begin
          nr_d    = bus.nr;
          // nr=0 is illegal anyway; clamp so round never wraps.
          round_d = (bus.nr == '0) ? '0 : bus.nr - NR_W'(1);
          if (nr_ok) begin
            state_d = S_ARK0;
            err_d   = 1'b0;
          end else begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end
        end
      end
      S_ARK0: if (bus.ark_done) state_d = S_BSS;
      S_BSS:  if (bus.bss_done) state_d = S_ARK;
      S_ARK:  if (bus.ark_done) state_d = S_MIX;
      S_MIX: begin
        if (bus.mix_done) begin
          if (round_q == NR_W'(1)) begin
            state_d = S_BSSL;
          end else begin
            if (round_q > NR_W'(1)) round_d = round_q - NR_W'(1);
            state_d = S_BSS;
          end
        end
      end
      S_BSSL: if (bus.bss_done) state_d = S_ARKL;
      S_ARKL: if (bus.ark_done) state_d = S_DONE;
      S_DONE: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Engine starts, key index and RAM owner decoded from the current state.
  always_comb begin
    bus.ark_start = 1'b0;
    bus.bss_start = 1'b0;
    bus.mix_start = 1'b0;
    bus.ark_n     = '0;
    bus.mem_sel   = MEM_NONE;
    bus.ap_done   = 1'b0;
    bus.err       = 1'b0;
    unique case (state_q)
      S_ARK0: begin
        bus.ark_start = 1'b1;
        bus.ark_n     = nr_q;
        bus.mem_sel   = MEM_ARK;
      end
      S_BSS, S_BSSL: begin
        bus.bss_start = 1'b1;
        bus.mem_sel   = MEM_BSS;
      end
      S_ARK: begin
        bus.ark_start = 1'b1;
        bus.ark_n     = round_q;
        bus.mem_sel   = MEM_ARK;
      end
      S_MIX: begin
        bus.mix_start = 1'b1;
        bus.mem_sel   = MEM_MIX;
      end
      S_ARKL: begin
        bus.ark_start = 1'b1;
        bus.mem_sel   = MEM_ARK;
      end
      S_DONE: begin
        bus.ap_done = 1'b1;
        bus.err     = err_q;
      end
      default: ;
    endcase
    bus.ap_ready = bus.ap_done;
    bus.ap_idle  = (state_q == S_IDLE) && !bus.ap_start;
    bus.round    = round_q;
  end

endmodule

// File: tb/tb_aes_round_sched.sv
// Randomized scoreboard bench for aes_round_sched: a stimulus process issues
// blocks and queues the expected outcome, a responder plays the three
// engines with a programmable done delay, and a monitor checks every cycle.
module tb_aes_round_sched;
  import aes_pkg::*;

  localparam int NR_W = 5;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;

  aes_round_sched_if #(.NR_W(NR_W)) bus ();

  aes_round_sched #(.NR_W(NR_W)) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    int nr;
    int d;
    bit err;
    int lat;
    int n_ark;
    int n_mix;
    int n_phase;
    bit b2b;
  } blk_t;

  blk_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   dly    = 0;
  bit   spur   = 1'b0;
  int   phase_idx = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit nr_legal(input int v);
    return (v == 10) || (v == 12) || (v == 14);
  endfunction

  // Reference model: 3*nr phases of (d+1) cycles each, keys nr..0,
  // nr-1 InvMixColumns phases; illegal nr goes straight to done with err.
  task automatic issue(input int nrv, input int dv, input bit spv, input bit b2b);
    blk_t b;
    b.nr  = nrv;
    b.d   = dv;
    b.b2b = b2b;
    b.err = !nr_legal(nrv);
    if (nr_legal(nrv)) begin
      b.lat     = 3 * nrv * (dv + 1) + 1;
      b.n_ark   = nrv + 1;
      b.n_mix   = nrv - 1;
      b.n_phase = 3 * nrv;
    end else begin
      b.lat     = 1;
      b.n_ark   = 0;
      b.n_mix   = 0;
      b.n_phase = 0;
    end
    sb_q.push_back(b);
    dly          = dv;
    spur         = spv;
    bus.nr       = NR_W'(nrv);
    bus.ap_start = 1'b1;
  endtask

  task automatic recover();
    @(posedge ap_clk);
    #1;
    ap_rst       = 1'b1;
    bus.ap_start = 1'b0;
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
  endtask

  // Waits for ap_done while scrambling nr after capture; nr must be ignored.
  task automatic wait_done(input int dv, output bit ok);
    int limit;
    limit = 3 * 14 * (dv + 1) + 10;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge ap_clk);
      if (bus.ap_done) begin
        ok = 1'b1;
        break;
      end
      if (i > 0) bus.nr = NR_W'($urandom_range(0, 31));
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ap_done_timeout: got no ap_done within %0d cycles, expected one pulse", limit);
      recover();
    end
  endtask

  task automatic run(input int nrv, input int dv, input bit spv);
    bit ok;
    @(posedge ap_clk);
    #1;
    issue(nrv, dv, spv, 1'b0);
    wait_done(dv, ok);
    if (ok) begin
      @(posedge ap_clk);
      #1;
      bus.ap_start = 1'b0;
    end
  endtask

  task automatic run_b2b(input int nr1, input int d1, input int nr2, input int d2);
    bit ok;
    @(posedge ap_clk);
    #1;
    issue(nr1, d1, 1'b0, 1'b0);
    wait_done(d1, ok);
    if (!ok) return;
    @(posedge ap_clk);
    #1;
    issue(nr2, d2, 1'b0, 1'b1);
    wait_done(d2, ok);
    if (ok) begin
      @(posedge ap_clk);
      #1;
      bus.ap_start = 1'b0;
    end
  endtask

  // Engine model: done after dly extra cycles; optional spurious dones
  // on engines that are not currently started.
  int c_ark = 0;
  int c_bss = 0;
  int c_mix = 0;
  initial begin
    bus.ark_done = 1'b0;
    bus.bss_done = 1'b0;
    bus.mix_done = 1'b0;
    forever begin
      @(posedge ap_clk);
      #2;
      if (bus.ark_start) begin
        bus.ark_done = (c_ark >= dly);
        c_ark++;
      end else begin
        c_ark = 0;
        bus.ark_done = spur ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (bus.bss_start) begin
        bus.bss_done = (c_bss >= dly);
        c_bss++;
      end else begin
        c_bss = 0;
        bus.bss_done = spur ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (bus.mix_start) begin
        bus.mix_done = (c_mix >= dly);
        c_mix++;
      end else begin
        c_mix = 0;
        bus.mix_done = spur ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  // Monitor state
  bit              m_busy      = 1'b0;
  bit              m_post_rst  = 1'b0;
  blk_t            m_blk;
  int              m_t         = 0;
  int              m_ark       = 0;
  int              m_mix       = 0;
  int              m_eng_cur   = 0;
  int              m_len       = 0;
  int              m_prev_eng  = 0;
  int              m_since_done = 100;
  logic [NR_W-1:0] m_prev_round = '0;

  always @(negedge ap_clk) begin
    int eng;
    int ns;
    ns  = int'(bus.ark_start) + int'(bus.bss_start) + int'(bus.mix_start);
    eng = bus.ark_start ? 1 : bus.bss_start ? 2 : bus.mix_start ? 3 : 0;
    if (ap_rst) begin
      if (m_busy) begin
        void'(sb_q.pop_front());
        m_busy = 1'b0;
      end
      m_post_rst = 1'b1;
      eng = 0;
    end else begin
      if (m_post_rst) begin
        chk("post_rst_starts", ns, 0);
        chk("post_rst_round", bus.round, 0);
        chk("post_rst_mem_sel", bus.mem_sel, 0);
        m_post_rst = 1'b0;
      end
      chk("ap_ready_eq_done", bus.ap_ready, bus.ap_done);
      if (!bus.ap_done) chk("err_low", bus.err, 0);
      if (m_busy) begin
        m_t++;
        chk("ap_idle_busy", bus.ap_idle, 0);
        if (m_prev_eng == 1 || m_prev_eng == 2) chk("round_hold", bus.round, m_prev_round);
        if (eng != m_eng_cur) begin
          if (m_eng_cur != 0) chk("phase_len", m_len, m_blk.d + 1);
          m_eng_cur = eng;
          m_len = 1;
          if (eng != 0) begin
            phase_idx++;
            if (eng == 1) begin
              chk("ark_n", bus.ark_n, m_blk.nr - m_ark);
              m_ark++;
            end
            if (eng == 3) m_mix++;
          end
        end else begin
          m_len++;
        end
        if (bus.ap_done) begin
          chk("done_starts", ns, 0);
          chk("done_mem_sel", bus.mem_sel, 0);
          chk("err", bus.err, m_blk.err);
          chk("latency", m_t, m_blk.lat);
          chk("ark_phases", m_ark, m_blk.n_ark);
          chk("mix_phases", m_mix, m_blk.n_mix);
          chk("phases", phase_idx, m_blk.n_phase);
          void'(sb_q.pop_front());
          m_busy = 1'b0;
          m_since_done = 0;
        end else begin
          chk("one_start", ns, 1);
          chk("mem_sel", bus.mem_sel, eng);
        end
      end else begin
        m_since_done++;
        chk("idle_starts", ns, 0);
        chk("idle_mem_sel", bus.mem_sel, 0);
        chk("idle_done", bus.ap_done, 0);
        chk("ap_idle", bus.ap_idle, !bus.ap_start);
        if (bus.ap_start) begin
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_capture: got a start with nothing queued, expected none");
          end else begin
            m_blk     = sb_q[0];
            m_busy    = 1'b1;
            m_t       = 0;
            m_ark     = 0;
            m_mix     = 0;
            phase_idx = 0;
            m_eng_cur = 0;
            m_len     = 0;
            if (m_blk.b2b) chk("b2b_gap", m_since_done, 1);
          end
        end
      end
    end
    m_prev_eng   = eng;
    m_prev_round = bus.round;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test by %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  // Stimulus
  initial begin
    bit ok;
    int nrv;
    int dv;
    bus.ap_start = 1'b0;
    bus.nr       = '0;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    chk("rst_ap_done", bus.ap_done, 0);
    chk("rst_ap_ready", bus.ap_ready, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_starts", int'(bus.ark_start) + int'(bus.bss_start) + int'(bus.mix_start), 0);
    chk("rst_mem_sel", bus.mem_sel, 0);
    chk("rst_round", bus.round, 0);
    chk("rst_ap_idle", bus.ap_idle, 1);
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;

    run(10, 0, 1'b0);
    run(14, 3, 1'b0);
    run(11, 0, 1'b0);

    // Reset in the middle of the 5th phase, then a clean nr=12 block.
    @(posedge ap_clk);
    #1;
    issue(12, 1, 1'b0, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge ap_clk);
      #1;
      if (phase_idx >= 5) begin
        ok = 1'b1;
        break;
      end
    end
    chk("reach_phase5", ok, 1);
    @(posedge ap_clk);
    #1;
    ap_rst       = 1'b1;
    bus.ap_start = 1'b0;
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    run(12, 0, 1'b0);

    run(10, 2, 1'b1);
    run_b2b(12, 0, 10, 1);

    for (int k = 0; k < 16; k++) begin
      case ($urandom_range(0, 4))
        0: nrv = 10;
        1: nrv = 12;
        2: nrv = 14;
        3: begin
          do nrv = int'($urandom_range(0, 31)); while (nr_legal(nrv));
        end
        default: nrv = 10 + 2 * int'($urandom_range(0, 2));
      endcase
      dv = int'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0)
        run_b2b(nrv, dv, 10 + 2 * int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      else
        run(nrv, dv, 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge ap_clk);
    chk("scoreboard_empty", sb_q.size(), 0);
    chk("monitor_idle", m_busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
